regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read register file for the brisc core.
- Supports N read ports and M write ports, with an optional hard-wired zero register and optional write-to-read bypass.
- Includes an integrated busy scoreboard. Decode uses it to detect RAW hazards on pending writebacks.
- Sits between decode (reads, allocation) and writeback (writes, busy clear).

Parameters:
- XLEN_P, default brisc_pkg::XLEN: data width of each register.
- REG_NUM, default 32: number of architectural registers; must be a power of two and at least 2.
- NUM_RD, default 2: number of read ports.
- NUM_WR, default 1: number of write ports.
- ZERO_REG, default 1: when 1, register 0 always reads 0, is never written, and is never busy.
- BYPASS, default 1: when 1, a same-cycle write is forwarded to matching reads.
- Derived localparam RegBits = $clog2(REG_NUM). This is the address width; it is derived from the register count, not the data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD x RegBits  read addresses.
- rd_data  out  NUM_RD x XLEN_P  read data.
- rd_busy  out  NUM_RD  addressed register has a write pending.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR x RegBits  write addresses.
- wr_data  in  NUM_WR x XLEN_P  write data.
- alloc_en  in  1  mark a destination register as pending.
- alloc_addr  in  RegBits  register to mark as pending.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset:
  - reset=0 asynchronously clears every register and every busy bit.
  - While reset is held: rd_data=0, rd_busy=0, any_busy=0.
  - Deassertion is sampled on the next rising edge of clk.
- Write timing:
  - On the rising edge with wr_en[j]=1, regs[wr_addr[j]] <= wr_data[j].
  - The new value is architecturally visible from the next cycle.
- Multiple writes to one address in the same cycle: the highest-index port wins.
- ZERO_REG=1: writes to address 0 are dropped, busy[0] is never set, and reads of address 0 return 0 and rd_busy=0.
- Read path: combinational, zero latency.
  - BYPASS=0: rd_data[i] = regs[rd_addr[i]].
  - BYPASS=1: if any wr_en[j] is set with wr_addr[j]==rd_addr[i] (and the address is not the zero register), rd_data[i] = wr_data of the highest such j; otherwise the stored value.
- Scoreboard, per register k, evaluated each edge:
  - set when alloc_en && alloc_addr==k;
  - clear when any wr_en[j] && wr_addr[j]==k;
  - set and clear in the same cycle: set wins, so busy stays 1 (a new producer supersedes the retiring one);
  - otherwise hold.
  - Allocating an already-busy register keeps it busy. There is no counting; one write clears it.
- rd_busy[i]:
  - BYPASS=1: busy[rd_addr[i]] && !(a same-cycle write to rd_addr[i]), because the bypassed data is valid.
  - BYPASS=0: busy[rd_addr[i]].
- any_busy = OR of busy[REG_NUM-1:0]; it is registered state, so no combinational path from wr_en.
- No X propagation: every output is driven at all times. Out-of-range addresses are impossible given the power-of-two REG_NUM.

Decomposition:
- brisc_pkg additions:
  - REG_NUM constant (32);
  - REG_ADDR_BITS = $clog2(REG_NUM);
  - typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
  - typedef logic [XLEN-1:0] word_t.
- Sub-module regfile_scoreboard: holds the busy vector, takes alloc and write-clear inputs, and outputs the busy vector and any_busy.
- The data array stays in regfile_mp as a generate loop of existing ff instances, with a per-register enable decoded from wr_en/wr_addr.

Test Plan:
- Reset mid-operation: write regs 1..31 with 0xA5A5_0000+k, pull reset=0 between clock edges → all rd_data read 0 immediately and any_busy=0; after release, read x5 = 0.
- Zero register: with ZERO_REG=1, write x0=0xDEADBEEF → next cycle rd_addr=0 gives 0; alloc x0 → rd_busy=0 and any_busy=0.
- Bypass: with BYPASS=1, write x7=0x1234 while reading x7 in the same cycle → rd_data=0x1234 in that cycle; with BYPASS=0 → old value 0 that cycle, 0x1234 the next.
- Write conflict: NUM_WR=2, both ports write x3 (0x11 on port 0, 0x22 on port 1) → x3=0x22 next cycle; a bypassed read of x3 in that cycle also returns 0x22.
- Scoreboard: alloc x9 → next cycle rd_busy=1 and any_busy=1; write x9 → that cycle rd_busy=0 (bypass), next cycle busy cleared and any_busy=0.
- Scoreboard race: alloc x4 and write x4 in the same cycle while x4 is busy → x4 remains busy next cycle and x4 holds the written value.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared brisc core constants and types: data width, register count and address width.
package brisc_pkg;

    localparam int XLEN          = 32;
    localparam int REG_NUM       = 32;
    localparam int REG_ADDR_BITS = $clog2(REG_NUM);

    typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]          word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file: decode allocates a pending destination, writeback clears it.
module regfile_scoreboard #(
    parameter  int REG_NUM  = 32,
    parameter  int NUM_WR   = 1,
    parameter  int ZERO_REG = 1,
    localparam int RegBits  = $clog2(REG_NUM)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_en,
    input  logic [RegBits-1:0]             alloc_addr,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][RegBits-1:0] wr_addr,
    output logic [REG_NUM-1:0]             busy,
    output logic                           any_busy
);

    logic [REG_NUM-1:0] set_v;
    logic [REG_NUM-1:0] clr_v;
    logic [REG_NUM-1:0] busy_nxt;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            if (alloc_en && alloc_addr == RegBits'(k))
                set_v[k] = 1'b1;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j] == RegBits'(k))
                    clr_v[k] = 1'b1;
            end
        end
        // A new producer supersedes the retiring one, so set dominates clear.
        busy_nxt = (busy & ~clr_v) | set_v;
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            any_busy <= |busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with optional zero register, write-to-read bypass
// and an integrated busy scoreboard for RAW hazard detection in decode.
module regfile_mp #(
    parameter  int XLEN_P   = brisc_pkg::XLEN,
    parameter  int REG_NUM  = brisc_pkg::REG_NUM,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 1,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int RegBits  = $clog2(REG_NUM)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0][RegBits-1:0] rd_addr,
    output logic [NUM_RD-1:0][XLEN_P-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][RegBits-1:0] wr_addr,
    input  logic [NUM_WR-1:0][XLEN_P-1:0]  wr_data,
    input  logic                           alloc_en,
    input  logic [RegBits-1:0]             alloc_addr,
    output logic                           any_busy
);

    logic [XLEN_P-1:0]  regs   [REG_NUM];
    logic [XLEN_P-1:0]  reg_wd [REG_NUM];
    logic [REG_NUM-1:0] reg_we;
    logic [REG_NUM-1:0] busy;

    // Per-register write decode; ascending port scan lets the highest port win.
    always_comb begin
        for (int k = 0; k < REG_NUM; k++) begin
            reg_we[k] = 1'b0;
            reg_wd[k] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j] == RegBits'(k)) begin
                    reg_we[k] = 1'b1;
                    reg_wd[k] = wr_data[j];
                end
            end
            if (ZERO_REG != 0 && k == 0)
                reg_we[k] = 1'b0;
        end
    end

    for (genvar k = 0; k < REG_NUM; k++) begin : g_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                regs[k] <= '0;
            else if (reg_we[k])
                regs[k] <= reg_wd[k];
        end
    end

    regfile_scoreboard #(
        .REG_NUM  (REG_NUM),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .any_busy   (any_busy)
    );

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            logic hit;
            hit        = 1'b0;
            rd_data[i] = regs[rd_addr[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[j] == rd_addr[i]) begin
                        hit        = 1'b1;
                        rd_data[i] = wr_data[j];
                    end
                end
            end
            // Forwarded data is valid this cycle, so it no longer counts as a hazard.
            rd_busy[i] = busy[rd_addr[i]] && !hit;
            if ((ZERO_REG != 0 && rd_addr[i] == '0) || !reset) begin
                rd_data[i] = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule
